// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, reservation, decode-hazard and register-file write signals
// shared between the execute/memory stages and the writeback arbiter.
interface regfile_wb_arbiter_if #(
    parameter int N = 32
);
    logic         alu_valid;
    logic [5:0]   alu_addr;
    logic [N-1:0] alu_data;
    logic         alu_ready;

    logic         mem_valid;
    logic [5:0]   mem_addr;
    logic [N-1:0] mem_data;
    logic         mem_ready;

    logic         rsv_valid;
    logic [5:0]   rsv_addr;
    logic         rsv_ready;

    logic [5:0]   rs1;
    logic [5:0]   rs2;
    logic         stall;
    logic [31:0]  busy;

    logic         regw;
    logic [5:0]   waddr;
    logic [N-1:0] wdata;

    modport master (
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        output rsv_valid, rsv_addr,
        input  rsv_ready,
        output rs1, rs2,
        input  stall, busy,
        input  regw, waddr, wdata
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        input  rsv_valid, rsv_addr,
        output rsv_ready,
        input  rs1, rs2,
        output stall, busy,
        output regw, waddr, wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port between ALU and load writeback,
// with a registered write stage (1 cycle) and a pending-write scoreboard driving decode stall.
module regfile_wb_arbiter #(
    parameter int N = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    regfile_wb_arbiter_if.slave bus
);
    typedef enum logic {
        LG_ALU = 1'b0,
        LG_MEM = 1'b1
    } grant_e;

    grant_e       r_last;
    grant_e       w_last_nxt;
    logic         w_gnt_alu;
    logic         w_gnt_mem;
    logic [5:0]   w_win_addr;
    logic [N-1:0] w_win_data;

    logic         r_regw;
    logic [5:0]   r_waddr;
    logic [N-1:0] r_wdata;

    logic [31:1]  r_pend;
    logic [31:0]  w_pend;
    logic [31:0]  w_set;
    logic [31:0]  w_clr;
    logic         w_rsv_ready;
    logic         w_unused_bits;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= LG_MEM;
        end else begin
            r_last <= w_last_nxt;
        end
    end

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        w_gnt_alu  = 1'b0;
        w_gnt_mem  = 1'b0;
        w_last_nxt = r_last;
        w_win_addr = bus.alu_addr;
        w_win_data = bus.alu_data;
        w_gnt_alu  = bus.alu_valid & (~bus.mem_valid | (r_last == LG_MEM));
        w_gnt_mem  = bus.mem_valid & ~w_gnt_alu;
        if (w_gnt_alu) begin
            w_last_nxt = LG_ALU;
        end else if (w_gnt_mem) begin
            w_last_nxt = LG_MEM;
            w_win_addr = bus.mem_addr;
            w_win_data = bus.mem_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_regw  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_gnt_alu || w_gnt_mem) begin
            r_regw  <= (w_win_addr[4:0] != 5'd0);
            r_waddr <= w_win_addr;
            r_wdata <= w_win_data;
        end else begin
            r_regw  <= 1'b0;
        end
    end

    // x0 is never pending, so its slot is tied low rather than stored.
    always_comb begin
        w_pend      = {r_pend, 1'b0};
        w_rsv_ready = ~w_pend[bus.rsv_addr[4:0]];
        w_set       = '0;
        w_clr       = '0;
        if (bus.rsv_valid && w_rsv_ready && (bus.rsv_addr[4:0] != 5'd0)) begin
            w_set[bus.rsv_addr[4:0]] = 1'b1;
        end
        if (r_regw) begin
            w_clr[r_waddr[4:0]] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr[31:1]) | w_set[31:1];
        end
    end

    assign bus.alu_ready = w_gnt_alu;
    assign bus.mem_ready = w_gnt_mem;
    assign bus.rsv_ready = w_rsv_ready;
    assign bus.busy      = w_pend;
    assign bus.stall     = (w_pend[bus.rs1[4:0]] & (bus.rs1[4:0] != 5'd0)) |
                           (w_pend[bus.rs2[4:0]] & (bus.rs2[4:0] != 5'd0));
    assign bus.regw      = r_regw;
    assign bus.waddr     = r_waddr;
    assign bus.wdata     = r_wdata;

    assign w_unused_bits = &{1'b0, bus.rsv_addr[5], bus.rs1[5], bus.rs2[5],
                             w_set[0], w_clr[0]};
endmodule
